// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA modular exponentiation core.
package rsa_pkg;

    localparam int RSA_WIDTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REDUCE,
        ST_CHECK,
        ST_MUL,
        ST_SQR,
        ST_DONE
    } rsa_state_e;

endpackage

// File: rtl/rsa_if.sv
// Control handshake between the RSA control FSM and the modexp core.
interface rsa_if
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH
) ();

    logic             en_rsa;
    logic             rst_rsa;
    logic [WIDTH-1:0] plain;
    logic [WIDTH-1:0] exp_key;
    logic [WIDTH-1:0] modulus;
    logic [WIDTH-1:0] cipher;
    logic             eoc_rsa_unit;
    logic             busy;

    modport master (
        output en_rsa, rst_rsa, plain, exp_key, modulus,
        input  cipher, eoc_rsa_unit, busy
    );

    modport slave (
        input  en_rsa, rst_rsa, plain, exp_key, modulus,
        output cipher, eoc_rsa_unit, busy
    );

endinterface

// File: rtl/rsa_mmm.sv
// Serial interleaved modular multiplier: p = a*b mod m, MSB-first over a.
module rsa_mmm
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             ena,
    input  logic             hold,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] p,
    output logic             done
);

    localparam int AW = WIDTH + 2;
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, m_q, m_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [AW-1:0]    t0, t1, t2, mw;

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        m_d    = m_q;
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        done_d = done_q;
        mw     = {2'b00, m_q};
        // 2*acc + b < 3m, so two conditional subtracts restore acc < m
        t0 = {acc_q[WIDTH:0], 1'b0} + (a_q[WIDTH-1] ? {2'b00, b_q} : '0);
        t1 = (t0 >= mw) ? t0 - mw : t0;
        t2 = (t1 >= mw) ? t1 - mw : t1;
        if (!hold) begin
            done_d = 1'b0;
            if (start) begin
                a_d   = a;
                b_d   = b;
                m_d   = m;
                acc_d = '0;
                cnt_d = CW'(WIDTH);
            end else if (cnt_q != '0) begin
                acc_d  = t2;
                a_d    = {a_q[WIDTH-2:0], 1'b0};
                cnt_d  = cnt_q - CW'(1);
                done_d = (cnt_q == CW'(1));
            end
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            a_q    <= '0;
            b_q    <= '0;
            m_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else if (ena) begin
            a_q    <= a_d;
            b_q    <= b_d;
            m_q    <= m_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign p    = acc_q[WIDTH-1:0];
    assign done = done_q;

endmodule

// File: rtl/rsa_modexp_core.sv
// Right-to-left square-and-multiply modexp over one shared serial multiplier.
module rsa_modexp_core
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH
) (
    input logic  clk,
    input logic  rstb,
    input logic  ena,
    rsa_if.slave bus
);

    localparam int IW = $clog2(WIDTH + 1);

    rsa_state_e       state_q, state_d;
    logic [WIDTH-1:0] plain_q, plain_d, exp_q, exp_d, mod_q, mod_d;
    logic [WIDTH-1:0] base_q, base_d, result_q, result_d;
    logic [WIDTH-1:0] cipher_q, cipher_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             issued_q, issued_d;
    logic             eoc_q, eoc_d, busy_q, busy_d;
    logic             pause, start, mmm_done;
    logic [WIDTH-1:0] mmm_a, mmm_b, mmm_p;

    function automatic rsa_state_e chk_next(input logic [IW-1:0]    k,
                                            input logic [WIDTH-1:0] e);
        logic [WIDTH-1:0] sh;
        sh = e >> k;
        if (k == IW'(WIDTH)) return ST_DONE;
        if (sh[0]) return ST_MUL;
        return ST_SQR;
    endfunction

    assign pause = busy_q & ~bus.en_rsa;

    always_comb begin
        mmm_a = base_q;
        mmm_b = base_q;
        if (state_q == ST_REDUCE) begin
            mmm_a = plain_q;
            mmm_b = WIDTH'(1);
        end else if (state_q == ST_MUL) begin
            mmm_a = result_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        plain_d  = plain_q;
        exp_d    = exp_q;
        mod_d    = mod_q;
        base_d   = base_q;
        result_d = result_q;
        cipher_d = cipher_q;
        idx_d    = idx_q;
        issued_d = issued_q;
        eoc_d    = eoc_q;
        busy_d   = busy_q;
        start    = 1'b0;
        if (!bus.rst_rsa) begin
            state_d  = ST_IDLE;
            cipher_d = '0;
            eoc_d    = 1'b0;
            busy_d   = 1'b0;
            issued_d = 1'b0;
        end else if (!pause) begin
            unique case (state_q)
                ST_IDLE: if (bus.en_rsa) begin
                    plain_d  = bus.plain;
                    exp_d    = bus.exp_key;
                    mod_d    = bus.modulus;
                    busy_d   = 1'b1;
                    idx_d    = '0;
                    issued_d = 1'b0;
                    result_d = (bus.modulus <= WIDTH'(1)) ? '0 : WIDTH'(1);
                    state_d  = (bus.modulus == '0) ? ST_DONE : ST_REDUCE;
                end
                ST_CHECK: state_d = chk_next(idx_q, exp_q);
                ST_REDUCE, ST_MUL, ST_SQR: begin
                    if (!issued_q) begin
                        start    = 1'b1;
                        issued_d = 1'b1;
                    end else if (mmm_done) begin
                        // writeback also resolves the CHECK decision
                        issued_d = 1'b0;
                        if (state_q == ST_MUL) begin
                            result_d = mmm_p;
                            state_d  = ST_SQR;
                        end else if (state_q == ST_SQR) begin
                            base_d  = mmm_p;
                            idx_d   = idx_q + IW'(1);
                            state_d = chk_next(idx_q + IW'(1), exp_q);
                        end else begin
                            base_d  = mmm_p;
                            state_d = chk_next(idx_q, exp_q);
                        end
                    end
                end
                ST_DONE: begin
                    cipher_d = result_q;
                    eoc_d    = 1'b1;
                    busy_d   = 1'b0;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q  <= ST_IDLE;
            plain_q  <= '0;
            exp_q    <= '0;
            mod_q    <= '0;
            base_q   <= '0;
            result_q <= '0;
            cipher_q <= '0;
            idx_q    <= '0;
            issued_q <= 1'b0;
            eoc_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else if (ena) begin
            state_q  <= state_d;
            plain_q  <= plain_d;
            exp_q    <= exp_d;
            mod_q    <= mod_d;
            base_q   <= base_d;
            result_q <= result_d;
            cipher_q <= cipher_d;
            idx_q    <= idx_d;
            issued_q <= issued_d;
            eoc_q    <= eoc_d;
            busy_q   <= busy_d;
        end
    end

    rsa_mmm #(.WIDTH(WIDTH)) u_mmm (
        .clk  (clk),
        .rstb (rstb),
        .ena  (ena),
        .hold (pause),
        .start(start),
        .a    (mmm_a),
        .b    (mmm_b),
        .m    (mod_q),
        .p    (mmm_p),
        .done (mmm_done)
    );

    assign bus.cipher       = cipher_q;
    assign bus.eoc_rsa_unit = eoc_q;
    assign bus.busy         = busy_q;

endmodule
